decode_stage: RTL

Registered, flow-controlled instruction decode stage that replaces the purely combinational field splitter between fetch and register read. Accepts one 32-bit instruction (plus PC) per cycle on a valid/ready handshake. Outputs the split register fields, a one-hot instruction class, use/write flags, and a single sign-extended immediate widened to ARCH_BITS. A 2-entry buffer (output register plus skid register) gives full throughput under back-pressure, and a flush discards in-flight work.

---
 rtl/decode_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Registered decode stage: splits fields, one-hot class, flags and extended immediate; 1-cycle latency.
// Two-entry buffer (main + skid) sustains full rate under back-pressure; in_ready comes straight from skid state.
module decode_stage #(
   parameter int ARCH_BITS   = 32,
   parameter bit MOVI_SIGNED = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [31:0]          i_in_inst,
   input  logic [ARCH_BITS-1:0] i_in_pc,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [ARCH_BITS-1:0] o_out_pc,
   output logic [6:0]           o_out_opcode,
   output logic [4:0]           o_out_dst,
   output logic [4:0]           o_out_src1,
   output logic [4:0]           o_out_src2,
   output logic [3:0]           o_out_class,
   output logic [ARCH_BITS-1:0] o_out_imm,
   output logic                 o_out_uses_src2,
   output logic                 o_out_writes_dst
);

   typedef struct packed {
      logic [ARCH_BITS-1:0] pc;
      logic [6:0]           opcode;
      logic [4:0]           dst;
      logic [4:0]           src1;
      logic [4:0]           src2;
      logic [3:0]           cls;
      logic [ARCH_BITS-1:0] imm;
      logic                 uses_src2;
      logic                 writes_dst;
   } bundle_t;

   bundle_t     w_dec;
   bundle_t     r_main;
   bundle_t     r_skid;
   logic        r_main_vld;
   logic        r_skid_vld;
   logic [19:0] w_b20;
   logic        w_movi_ext;
   logic        w_accept;
   logic        w_drain;

   assign w_b20      = {i_in_inst[24:20], i_in_inst[14:10], i_in_inst[9:0]};
   assign w_movi_ext = MOVI_SIGNED & i_in_inst[19];

   always_comb begin
      w_dec            = '0;
      w_dec.pc         = i_in_pc;
      w_dec.opcode     = i_in_inst[31:25];
      w_dec.dst        = i_in_inst[24:20];
      w_dec.src1       = i_in_inst[19:15];
      w_dec.src2       = i_in_inst[14:10];
      // class is the top two opcode bits, so every opcode lands in exactly one class
      case (i_in_inst[31:30])
         2'b00: begin
            w_dec.cls        = 4'b0001;
            w_dec.uses_src2  = 1'b1;
            w_dec.writes_dst = 1'b1;
         end
         2'b01: begin
            w_dec.cls        = 4'b0010;
            w_dec.writes_dst = 1'b1;
            w_dec.imm        = {{(ARCH_BITS-15){i_in_inst[14]}}, i_in_inst[14:0]};
         end
         2'b10: begin
            w_dec.cls        = 4'b0100;
            w_dec.imm        = {{(ARCH_BITS-20){w_b20[19]}}, w_b20};
         end
         default: begin
            w_dec.cls        = 4'b1000;
            w_dec.writes_dst = 1'b1;
            w_dec.imm        = {{(ARCH_BITS-20){w_movi_ext}}, i_in_inst[19:0]};
         end
      endcase
   end

   assign o_in_ready = ~r_skid_vld;
   assign w_accept   = i_in_valid & ~r_skid_vld;
   assign w_drain    = r_main_vld & i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
         r_main     <= '0;
         r_skid     <= '0;
      end else if (i_flush) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (w_drain) begin
         if (r_skid_vld) begin
            r_main <= r_skid;
            if (w_accept) begin
               r_skid <= w_dec;
            end else begin
               r_skid_vld <= 1'b0;
            end
         end else begin
            r_main     <= w_dec;
            r_main_vld <= w_accept;
         end
      end else if (!r_main_vld) begin
         r_main     <= w_dec;
         r_main_vld <= w_accept;
      end else if (w_accept) begin
         // main is stalled: park the new instruction in skid
         r_skid     <= w_dec;
         r_skid_vld <= 1'b1;
      end
   end

   assign o_out_valid      = r_main_vld;
   assign o_out_pc         = r_main.pc;
   assign o_out_opcode     = r_main.opcode;
   assign o_out_dst        = r_main.dst;
   assign o_out_src1       = r_main.src1;
   assign o_out_src2       = r_main.src2;
   assign o_out_class      = r_main.cls;
   assign o_out_imm        = r_main.imm;
   assign o_out_uses_src2  = r_main.uses_src2;
   assign o_out_writes_dst = r_main.writes_dst;

endmodule
